rom_arbiter: RTL and testbench

Parametrised N-channel read arbiter and ROM download writer sitting between the core's ROM clients (program, sprite, sound, tile, …) and the 32-bit SDRAM controller. Each channel presents a channel-local 32-bit word address; the block adds that channel's base offset, arbitrates round-robin, and keeps at most one SDRAM read outstanding. It returns the data with a one-hot valid pulse. During ROM download it packs IOCTL bytes into 32-bit words and writes them to SDRAM.

---
 rtl/rom_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_rom_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// ROM client read arbiter (round-robin, one outstanding SDRAM read) plus IOCTL download word packer/writer.
// Optional one-entry per-channel read cache when ROM_ARBITER_CACHE_EN is defined.
module rom_arbiter #(
  parameter int unsigned          NUM_CH     = 4,
  parameter int unsigned          CH_AW      = 20,
  parameter logic [NUM_CH*23-1:0] CH_OFFSETS = '0,
  parameter logic [15:0]          DL_INDEX   = 16'd0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       ch_req,
  input  logic [NUM_CH*CH_AW-1:0] ch_addr,
  output logic [31:0]             ch_data,
  output logic [NUM_CH-1:0]       ch_valid,
  input  logic [24:0]             ioctl_addr,
  input  logic [7:0]              ioctl_data,
  input  logic [15:0]             ioctl_index,
  input  logic                    ioctl_wr,
  input  logic                    ioctl_download,
  output logic [22:0]             sdram_addr,
  output logic [31:0]             sdram_data,
  output logic                    sdram_we,
  output logic                    sdram_req,
  input  logic                    sdram_ack,
  input  logic                    sdram_valid,
  input  logic [31:0]             sdram_q
);
  localparam int unsigned SAW = 23;
  localparam int unsigned PW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, DL, DL_WR} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     ptr, ptr_n, grant, grant_n, idx;
  logic [SAW-1:0]    sdram_addr_n;
  logic [31:0]       sdram_data_n, ch_data_n, pack, pack_n;
  logic              sdram_we_n, sdram_req_n, found;
  logic [NUM_CH-1:0] ch_valid_n, req_eff;
  logic [SAW-1:0]    full_addr [NUM_CH];
  logic              hit_found;
  logic [PW-1:0]     hit_idx;
  logic [31:0]       hit_data;

  // A channel whose valid pulse is out this cycle is not re-served while its client lets go.
  assign req_eff = ch_req & ~ch_valid;

  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++)
      full_addr[i] = CH_OFFSETS[SAW*i +: SAW] + SAW'(ch_addr[CH_AW*i +: CH_AW]);
  end

`ifdef ROM_ARBITER_CACHE_EN
  logic [NUM_CH-1:0] c_valid;
  logic [CH_AW-1:0]  c_tag  [NUM_CH];
  logic [31:0]       c_data [NUM_CH];
  logic [CH_AW-1:0]  rd_addr;
  logic              dl_q, fill;

  // Lowest-index hit wins: the descending scan leaves the smallest match.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    hit_data  = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (req_eff[i] && c_valid[i] && (c_tag[i] == ch_addr[CH_AW*i +: CH_AW])) begin
        hit_found = 1'b1;
        hit_idx   = PW'(i);
        hit_data  = c_data[i];
      end
    end
  end

  assign fill = (state == RD_WAIT) && sdram_valid && ch_req[grant];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_valid <= '0;
      dl_q    <= 1'b0;
      rd_addr <= '0;
    end else begin
      dl_q <= ioctl_download;
      if (state == IDLE && state_n == RD_REQ)
        rd_addr <= ch_addr[CH_AW*grant_n +: CH_AW];
      if (ioctl_download && !dl_q)
        c_valid <= '0;
      if (fill)
        c_valid[grant] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      c_tag[grant]  <= rd_addr;
      c_data[grant] <= sdram_q;
    end
  end
`else
  assign hit_found = 1'b0;
  assign hit_idx   = '0;
  assign hit_data  = '0;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    grant_n      = grant;
    sdram_addr_n = sdram_addr;
    sdram_data_n = sdram_data;
    sdram_we_n   = sdram_we;
    sdram_req_n  = sdram_req;
    ch_data_n    = ch_data;
    ch_valid_n   = '0;
    pack_n       = pack;
    found        = 1'b0;
    idx          = '0;

    if ((state == DL || state == DL_WR) && ioctl_wr)
      pack_n[{ioctl_addr[1:0], 3'b000} +: 8] = ioctl_data;

    case (state)
      IDLE: begin
        if (ioctl_download) begin
          state_n = DL;
        end else if (hit_found) begin
          ch_data_n           = hit_data;
          ch_valid_n[hit_idx] = 1'b1;
        end else begin
          for (int k = 1; k <= int'(NUM_CH); k++) begin
            idx = PW'((int'(ptr) + k) % int'(NUM_CH));
            if (!found && req_eff[idx]) begin
              found   = 1'b1;
              grant_n = idx;
            end
          end
          if (found) begin
            sdram_addr_n = full_addr[grant_n];
            sdram_we_n   = 1'b0;
            sdram_req_n  = 1'b1;
            state_n      = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (sdram_ack) begin
          sdram_req_n = 1'b0;
          ptr_n       = grant;
          state_n     = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (sdram_valid) begin
          state_n = IDLE;
          if (ch_req[grant]) begin
            ch_data_n         = sdram_q;
            ch_valid_n[grant] = 1'b1;
          end
        end
      end
      DL: begin
        if (ioctl_wr && ioctl_addr[1:0] == 2'd3 && ioctl_index == DL_INDEX) begin
          sdram_data_n = {ioctl_data, pack[23:0]};
          sdram_addr_n = ioctl_addr[24:2];
          sdram_we_n   = 1'b1;
          sdram_req_n  = 1'b1;
          state_n      = DL_WR;
        end else if (!ioctl_download) begin
          state_n = IDLE;
        end
      end
      DL_WR: begin
        if (sdram_ack) begin
          sdram_req_n = 1'b0;
          sdram_we_n  = 1'b0;
          state_n     = DL;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= PW'(NUM_CH - 1);
      grant      <= '0;
      sdram_addr <= '0;
      sdram_data <= '0;
      sdram_we   <= 1'b0;
      sdram_req  <= 1'b0;
      ch_data    <= '0;
      ch_valid   <= '0;
      pack       <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      grant      <= grant_n;
      sdram_addr <= sdram_addr_n;
      sdram_data <= sdram_data_n;
      sdram_we   <= sdram_we_n;
      sdram_req  <= sdram_req_n;
      ch_data    <= ch_data_n;
      ch_valid   <= ch_valid_n;
      pack       <= pack_n;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: reference model queues expected SDRAM reads/writes and client returns.
module tb_rom_arbiter;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 20;
  localparam logic [NCH*23-1:0] OFFS = {23'h200000, 23'h100000, 23'h040000, 23'h7F0000};
  localparam logic [15:0] DLI = 16'd0;

  typedef struct {int ch; logic [22:0] addr; bit discard;} rd_t;
  typedef struct {int ch; logic [31:0] data;} cv_t;
  typedef struct {logic [22:0] addr; logic [31:0] data;} wr_t;
  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH-1:0]    ch_req;
  logic [NCH*AW-1:0] ch_addr;
  logic [31:0]       ch_data;
  logic [NCH-1:0]    ch_valid;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_data;
  logic [15:0]       ioctl_index;
  logic              ioctl_wr, ioctl_download;
  logic [22:0]       sdram_addr;
  logic [31:0]       sdram_data, sdram_q;
  logic              sdram_we, sdram_req, sdram_ack, sdram_valid;

  always #5 clk = ~clk;

  rom_arbiter #(.NUM_CH(NCH), .CH_AW(AW), .CH_OFFSETS(OFFS), .DL_INDEX(DLI)) dut (
    .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_addr(ch_addr), .ch_data(ch_data),
    .ch_valid(ch_valid), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid), .sdram_q(sdram_q));

  int n_tests = 0, n_fail = 0;
  int cv_count = 0, req_cycles = 0;
  int last_ch = NCH - 1;
  rd_t rd_q[$];
  cv_t cv_q[$];
  wr_t wr_q[$];
  bit          c_val [NCH];
  logic [AW-1:0] c_tag [NCH];
  logic [7:0]  pk [4];

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (a == 23'h040010) return 32'hDEADBEEF;
    return {1'b1, a[7:0], a} ^ 32'h5A5A0000;
  endfunction

  function automatic logic [22:0] sdram_of(input int ch, input logic [AW-1:0] a);
    logic [31:0] s;
    s = 32'(OFFS[23*ch +: 23]) + 32'(a);
    return s[22:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cache_invalidate();
    for (int i = 0; i < NCH; i++) c_val[i] = 1'b0;
  endtask

  // Reference: cached channels return first (ascending), then misses in round-robin order.
  task automatic model_round(input logic [NCH-1:0] mask, input logic [AW-1:0] a [NCH]);
    bit hit [NCH];
    int start, i;
    for (int j = 0; j < NCH; j++) hit[j] = 1'b0;
`ifdef ROM_ARBITER_CACHE_EN
    for (int j = 0; j < NCH; j++)
      if (mask[j] && c_val[j] && c_tag[j] == a[j]) begin
        hit[j] = 1'b1;
        cv_q.push_back('{j, mem_word(sdram_of(j, a[j]))});
      end
`endif
    start = last_ch;
    for (int k = 1; k <= NCH; k++) begin
      i = (start + k) % NCH;
      if (mask[i] && !hit[i]) begin
        rd_q.push_back('{i, sdram_of(i, a[i]), 1'b0});
        c_val[i] = 1'b1;
        c_tag[i] = a[i];
        last_ch  = i;
      end
    end
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    while (ch_req != '0 && n < 300) begin
      @(negedge clk);
      ch_req = ch_req & ~ch_valid;
      n++;
    end
    check("round_done", 32'(ch_req), 32'd0);
    ch_req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_round(input logic [NCH-1:0] mask, input logic [AW-1:0] a [NCH]);
    model_round(mask, a);
    for (int i = 0; i < NCH; i++) ch_addr[AW*i +: AW] = a[i];
    ch_req = mask;
    wait_clear();
  endtask

  task automatic wait_read_accepted();
    int n;
    n = 0;
    while (!sdram_req && n < 50) begin @(negedge clk); n++; end
    while (sdram_req && n < 100) begin @(negedge clk); n++; end
    check("read_accept", 32'(sdram_req), 32'd0);
  endtask

  task automatic do_download(input logic [15:0] idx, input logic [24:0] base, input byte_q_t bytes);
    logic [24:0] a;
    @(negedge clk);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    cache_invalidate();
    repeat (2) @(negedge clk);
    foreach (bytes[k]) begin
      a = base + 25'(k);
      pk[a[1:0]] = bytes[k];
      if (a[1:0] == 2'd3 && idx == DLI)
        wr_q.push_back('{a[24:2], {pk[3], pk[2], pk[1], pk[0]}});
      ioctl_addr = a;
      ioctl_data = bytes[k];
      ioctl_wr   = 1'b1;
      @(negedge clk);
      ioctl_wr = 1'b0;
      repeat (3) @(negedge clk);
    end
    ioctl_download = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // SDRAM side: random ack/data latency; checks each accepted request against the model.
  initial begin : sdram_model
    logic [22:0] a_seen;
    rd_t r;
    wr_t w;
    int d;
    sdram_ack = 1'b0; sdram_valid = 1'b0; sdram_q = '0;
    forever begin
      @(negedge clk);
      if (reset_n && sdram_req) begin
        a_seen = sdram_addr;
        d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          check("req_held", {8'd0, sdram_req, sdram_addr}, {8'd0, 1'b1, a_seen});
        end
        sdram_ack = 1'b1;
        if (sdram_we) begin
          n_tests++;
          if (wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: addr %h data %h", sdram_addr, sdram_data);
          end else begin
            w = wr_q.pop_front();
            n_tests--;
            check("wr_addr", 32'(sdram_addr), 32'(w.addr));
            check("wr_data", sdram_data, w.data);
          end
          @(negedge clk);
          sdram_ack = 1'b0;
        end else begin
          n_tests++;
          if (rd_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read: addr %h", sdram_addr);
          end else begin
            r = rd_q.pop_front();
            n_tests--;
            check("rd_addr", 32'(sdram_addr), 32'(r.addr));
            if (!r.discard) cv_q.push_back('{r.ch, mem_word(r.addr)});
          end
          @(negedge clk);
          sdram_ack = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          sdram_q     = mem_word(a_seen);
          sdram_valid = 1'b1;
          @(negedge clk);
          sdram_valid = 1'b0;
        end
      end
    end
  end

  // Client-side monitor: every valid pulse must match the next expected return.
  initial begin : client_monitor
    cv_t c;
    forever begin
      @(negedge clk);
      if (reset_n && sdram_req) req_cycles++;
      if (reset_n && ch_valid != '0) begin
        cv_count++;
        if (cv_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ch_valid: got %b data %h", ch_valid, ch_data);
        end else begin
          c = cv_q.pop_front();
          check("ch_valid", 32'(ch_valid), 32'd1 << c.ch);
          check("ch_data", ch_data, c.data);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [AW-1:0] arr [NCH];
    byte_q_t bq;
    int r0, cv0;
    ch_req = '0; ch_addr = '0; ioctl_addr = '0; ioctl_data = '0;
    ioctl_index = '0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
    for (int i = 0; i < 4; i++) pk[i] = 8'h00;
    cache_invalidate();

    repeat (3) @(negedge clk);
    check("rst_sdram_req_in_reset", 32'(sdram_req), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_ch_valid", 32'(ch_valid), 32'd0);
    check("rst_ch_data", ch_data, 32'd0);
    check("rst_sdram_req", 32'(sdram_req), 32'd0);
    check("rst_sdram_we", 32'(sdram_we), 32'd0);
    check("rst_sdram_addr", 32'(sdram_addr), 32'd0);
    check("rst_sdram_data", sdram_data, 32'd0);

    // All four requesting twice: order 0,1,2,3 then 0,1,2,3.
    arr = '{20'h00001, 20'h00002, 20'h00003, 20'h00004};
    run_round(4'b1111, arr);
    arr = '{20'h00010, 20'h00020, 20'h00030, 20'h00040};
    run_round(4'b1111, arr);

    arr = '{20'h00000, 20'h00010, 20'h00000, 20'h00000};
    run_round(4'b0010, arr);

    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_download(16'd0, 25'h100, bq);
    check("dl_write_done", 32'(wr_q.size()), 32'd0);
    r0 = req_cycles;
    bq = '{8'h55, 8'h66, 8'h77, 8'h88};
    do_download(16'd1, 25'h200, bq);
    check("dl_other_index_no_req", 32'(req_cycles - r0), 32'd0);

    // Requester drops before data: read completes on the bus but no valid pulse.
    ch_addr[AW*2 +: AW] = 20'hABCDE;
    rd_q.push_back('{2, sdram_of(2, 20'hABCDE), 1'b1});
    last_ch = 2;
    cv0 = cv_count;
    ch_req = 4'b0100;
    wait_read_accepted();
    ch_req = '0;
    repeat (10) @(negedge clk);
    check("discard_no_valid", 32'(cv_count - cv0), 32'd0);

    // Download raised while a read is in flight.
    ch_addr[0 +: AW]    = 20'h00777;
    ch_addr[AW*3 +: AW] = 20'h0F0F0;
    rd_q.push_back('{0, sdram_of(0, 20'h00777), 1'b0});
    last_ch = 0;
    ch_req = 4'b0001;
    wait_read_accepted();
    ioctl_download = 1'b1;
    ioctl_index    = 16'd1;
    cache_invalidate();
    c_val[0] = 1'b1;
    c_tag[0] = 20'h00777;
    ch_req[3] = 1'b1;
    for (int n = 0; n < 50 && ch_req[0]; n++) begin
      @(negedge clk);
      ch_req = ch_req & ~ch_valid;
    end
    check("dl_inflight_read_done", 32'(ch_req[0]), 32'd0);
    r0 = req_cycles;
    repeat (20) @(negedge clk);
    check("dl_blocks_grant", 32'(req_cycles - r0), 32'd0);
    check("dl_ch3_pending", 32'(ch_req[3]), 32'd1);
    rd_q.push_back('{3, sdram_of(3, 20'h0F0F0), 1'b0});
    last_ch  = 3;
    c_val[3] = 1'b1;
    c_tag[3] = 20'h0F0F0;
    ioctl_download = 1'b0;
    wait_clear();

`ifdef ROM_ARBITER_CACHE_EN
    arr = '{20'h00000, 20'h00000, 20'h12345, 20'h00000};
    run_round(4'b0100, arr);
    model_round(4'b0100, arr);
    ch_req = 4'b0100;
    @(negedge clk);
    check("cache_hit_latency", 32'(ch_valid), 32'h4);
    check("cache_hit_no_read", 32'(rd_q.size()), 32'd0);
    ch_req = ch_req & ~ch_valid;
    wait_clear();
    bq = '{8'hAA};
    do_download(16'd1, 25'h300, bq);
    run_round(4'b0100, arr);
    check("cache_miss_after_dl", 32'(rd_q.size()), 32'd0);
`endif

    // Randomized rounds with occasional downloads.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        bq = {};
        for (int k = 0; k < int'($urandom_range(4, 10)); k++) bq.push_back(8'($urandom));
        do_download(16'($urandom_range(0, 1)), 25'($urandom), bq);
      end else begin
        for (int i = 0; i < NCH; i++) arr[i] = AW'($urandom_range(0, 3) * 32'h31111);
        run_round(NCH'($urandom_range(1, 15)), arr);
      end
    end

    repeat (10) @(negedge clk);
    check("end_rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("end_cv_q_empty", 32'(cv_q.size()), 32'd0);
    check("end_wr_q_empty", 32'(wr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
